otter_fetch_prefetch: RTL

//  Instruction prefetch stage sitting directly upstream of OTTER_Memory.
//  - Generates the word address MEM_ADDR for the synchronous-read program memory.
//  - Captures MEM_DOUT one cycle later into a small FIFO.
//  - Presents {INSTR, INSTR_PC} to decode over a valid/ready handshake.
//  - Supports redirect (branch/jump) by squashing queued and in-flight fetches.

---
 rtl/otter_fetch_prefetch.sv | 117 +++++++++++
 1 files changed

// File: rtl/otter_fetch_prefetch.sv
// Instruction prefetch stage for OTTER_Memory: issues word reads, buffers the
// returned words in a small FIFO and hands them to decode over valid/ready.
module otter_fetch_prefetch #(
  parameter int unsigned            ADDR_WIDTH = 10,
  parameter int unsigned            FIFO_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = '0
) (
  input  logic                  MEM_CLK,
  input  logic                  MEM_RST_N,
  input  logic                  FETCH_EN,
  input  logic                  REDIRECT,
  input  logic [ADDR_WIDTH-1:0] REDIRECT_ADDR,
  output logic [ADDR_WIDTH-1:0] MEM_ADDR,
  input  logic [31:0]           MEM_DOUT,
  output logic                  INSTR_VALID,
  input  logic                  INSTR_READY,
  output logic [31:0]           INSTR,
  output logic [ADDR_WIDTH-1:0] INSTR_PC
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic                  pend_q;
  logic [ADDR_WIDTH-1:0] pend_pc_q;
  logic [31:0]           fifo_instr [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_pc    [FIFO_DEPTH];
  logic [PTR_W-1:0]      rd_ptr_q, wr_ptr_q, rd_next;
  logic [CNT_W-1:0]      count_q, occupancy, cnt_after_pop;
  logic [31:0]           instr_q, head_instr_d;
  logic [ADDR_WIDTH-1:0] instr_pc_q, head_pc_d;
  logic                  issue, push, pop, head_upd;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (FETCH_EN)  state_d = S_RUN;
      S_RUN:   if (!FETCH_EN) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Credit counts the in-flight read so a capture can never overflow the FIFO.
  assign occupancy   = count_q + CNT_W'(pend_q);
  assign issue       = (state_q == S_RUN) && !REDIRECT && (occupancy < CNT_W'(FIFO_DEPTH));
  assign push        = pend_q && !REDIRECT;
  assign pop         = INSTR_VALID && INSTR_READY && !REDIRECT;
  assign INSTR_VALID = (count_q != '0);
  assign MEM_ADDR    = pc_q;
  assign INSTR       = instr_q;
  assign INSTR_PC    = instr_pc_q;

  // Registered head: follows the next entry after a pop, or the incoming word
  // when it lands in an otherwise empty FIFO; holds its value when empty.
  always_comb begin
    rd_next       = rd_ptr_q + PTR_W'(pop);
    cnt_after_pop = count_q - CNT_W'(pop);
    head_upd      = !REDIRECT && ((cnt_after_pop != '0) || push);
    head_instr_d  = instr_q;
    head_pc_d     = instr_pc_q;
    if (cnt_after_pop != '0) begin
      head_instr_d = fifo_instr[rd_next];
      head_pc_d    = fifo_pc[rd_next];
    end else if (push) begin
      head_instr_d = MEM_DOUT;
      head_pc_d    = pend_pc_q;
    end
  end

  always_ff @(posedge MEM_CLK) begin
    if (MEM_RST_N && push) begin
      fifo_instr[wr_ptr_q] <= MEM_DOUT;
      fifo_pc[wr_ptr_q]    <= pend_pc_q;
    end
  end

  always_ff @(posedge MEM_CLK) begin
    if (!MEM_RST_N) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      pend_q     <= 1'b0;
      pend_pc_q  <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      instr_q    <= '0;
      instr_pc_q <= '0;
    end else begin
      state_q <= state_d;
      if (REDIRECT) begin
        pc_q     <= REDIRECT_ADDR;
        pend_q   <= 1'b0;
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        pend_q <= issue;
        if (issue) begin
          pend_pc_q <= pc_q;
          pc_q      <= pc_q + ADDR_WIDTH'(1);
        end
        if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        if (head_upd) begin
          instr_q    <= head_instr_d;
          instr_pc_q <= head_pc_d;
        end
      end
    end
  end

endmodule
